seq_alu: RTL and testbench

- Parametrised, handshaked successor to the datapath's combinational ALU; sits between decode/operand fetch and writeback.
- Performs single-cycle logic and arithmetic ops with a registered result.
- Optionally performs iterative unsigned multiply and divide (radix-2, one bit per cycle).
- Valid/ready on both sides, so the core can stall on long ops.

---
 rtl/seq_alu_pkg.sv | 27 ++
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu_muldiv_iter.sv | 77 +++++++
 rtl/seq_alu.sv | 122 ++++++++++++
 tb/tb_seq_alu.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode helpers for seq_alu.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus of seq_alu: valid/ready on both the operand and result side.
interface seq_alu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic [3:0]      ALUControl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] ALUResult;
    logic            zero;
    logic            op_illegal;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, zero, op_illegal
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, zero, op_illegal
    );
endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// Radix-2 iterative unsigned multiply / restoring divide, one bit per cycle.
// op_i[1] selects divide, op_i[0] selects the high half (mulhu) or remainder (remu).
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  m_q, m_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN:0]    add_sum;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    rem_diff;

    // hi holds partial product / remainder; lo holds multiplier / dividend-then-quotient.
    always_comb begin
        add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, m_q};
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        op_d     = op_q;
        done_o   = 1'b0;
        if (start_i) begin
            cnt_d = CNT_W'(XLEN);
            hi_d  = '0;
            lo_d  = op_i[1] ? a_i : b_i;
            m_d   = op_i[1] ? b_i : a_i;
            op_d  = op_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (op_q[1]) begin
                // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
                if (!rem_diff[XLEN]) begin
                    hi_d = rem_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_d = add_sum[XLEN:1];
                lo_d = {add_sum[0], lo_q[XLEN-1:1]};
            end
            done_o = (cnt_q == CNT_W'(1));
        end
        result_o = op_q[0] ? hi_d : lo_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            op_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            m_q   <= m_d;
            op_q  <= op_d;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result; iterative mul/div when ALU_MULDIV_EN is defined.
//   state  | meaning
//   S_IDLE | waiting for a request
//   S_BUSY | iterative mul/div in progress
//   S_DONE | result valid, held until out_ready
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    reset,
    seq_alu_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;
    logic            accept;
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic [SH_W-1:0] shamt;

    assign bus.in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign shamt        = bus.SrcB[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.ALUControl)
            OP_ADD:  alu_res = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_res = bus.SrcA - bus.SrcB;
            OP_AND:  alu_res = bus.SrcA & bus.SrcB;
            OP_OR:   alu_res = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_res = bus.SrcA ^ bus.SrcB;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (bus.SrcA < bus.SrcB)};
            OP_SLL:  alu_res = bus.SrcA << shamt;
            OP_SRL:  alu_res = bus.SrcA >> shamt;
            OP_SRA:  alu_res = $signed(bus.SrcA) >>> shamt;
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(XLEN) + 1;

    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .op_i     (bus.ALUControl[1:0]),
        .a_i      (bus.SrcA),
        .b_i      (bus.SrcB),
        .done_o   (md_done),
        .result_o (md_result)
    );
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        md_start  = 1'b0;
`endif
        if (accept) begin
            state_d   = S_DONE;
            result_d  = alu_res;
            illegal_d = alu_ill;
`ifdef ALU_MULDIV_EN
            if (is_muldiv(bus.ALUControl)) begin
                state_d   = S_BUSY;
                result_d  = result_q;
                illegal_d = illegal_q;
                md_start  = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                S_IDLE: ;
                S_DONE: if (bus.out_ready) state_d = S_IDLE;
`ifdef ALU_MULDIV_EN
                S_BUSY: begin
                    if (md_done) begin
                        state_d   = S_DONE;
                        result_d  = md_result;
                        illegal_d = 1'b0;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.ALUResult  = result_q;
    assign bus.zero       = (result_q == '0);
    assign bus.op_illegal = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against a transaction-level reference model.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef struct {
        logic [XLEN-1:0] res;
        bit              ill;
        longint          due;
        bit              le;
        logic [XLEN-1:0] lv;
        bit              li;
    } item_t;

    logic   clk;
    logic   reset;
    longint cyc;
    int     n_cmp;
    int     n_err;
    int     rdy_mode;
    bit              lit_en;
    logic [XLEN-1:0] lit_val;
    bit              lit_ill;
    item_t  exp_q[$];

    seq_alu_if #(.XLEN(XLEN)) bus();

    seq_alu #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
        end
    endtask

    // Reference: result, illegal flag and latency derived straight from the opcode semantics.
    function automatic void model(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                  output logic [XLEN-1:0] r, output bit ill, output int lat);
        logic [2*XLEN-1:0] p;
        int sh;
        sh  = int'(b % XLEN);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        p   = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd6: r = (a < b) ? 1 : 0;
            4'd7: r = a << sh;
            4'd8: r = a >> sh;
            4'd9: r = $signed(a) >>> sh;
`ifdef ALU_MULDIV_EN
            4'd12: begin r = p[XLEN-1:0];      lat = XLEN + 1; end
            4'd13: begin r = p[2*XLEN-1:XLEN]; lat = XLEN + 1; end
            4'd14: begin r = (b == 0) ? '1 : a / b; lat = XLEN + 1; end
            4'd15: begin r = (b == 0) ? a : a % b;  lat = XLEN + 1; end
`endif
            default: begin r = '0; ill = 1'b1; end
        endcase
    endfunction

    // Per-cycle compare against the model's notion of what is in flight.
    always @(negedge clk) begin
        item_t it;
        bit    exp_vld;
        bit    exp_rdy;
        int    lat;
        if (reset) begin
            exp_q.delete();
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_in_ready", bus.in_ready, 1'b1);
            chk("rst_result", bus.ALUResult, '0);
            chk("rst_zero", bus.zero, 1'b1);
            chk("rst_illegal", bus.op_illegal, 1'b0);
        end else begin
            exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            exp_rdy = (exp_q.size() == 0) ? 1'b1 : (exp_vld ? bus.out_ready : 1'b0);
            chk("out_valid", bus.out_valid, exp_vld);
            chk("in_ready", bus.in_ready, exp_rdy);
            if (exp_vld && bus.out_valid) begin
                chk("result", bus.ALUResult, exp_q[0].res);
                chk("op_illegal", bus.op_illegal, exp_q[0].ill);
                chk("zero", bus.zero, exp_q[0].res == '0);
                if (exp_q[0].le) begin
                    chk("lit_result", bus.ALUResult, exp_q[0].lv);
                    chk("lit_illegal", bus.op_illegal, exp_q[0].li);
                end
            end
            if (exp_vld && bus.out_ready) void'(exp_q.pop_front());
            if (bus.in_valid && exp_rdy) begin
                model(bus.ALUControl, bus.SrcA, bus.SrcB, it.res, it.ill, lat);
                it.due = cyc + lat;
                it.le  = lit_en;
                it.lv  = lit_val;
                it.li  = lit_ill;
                exp_q.push_back(it);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) bus.out_ready = 1'b1;
            else if (rdy_mode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit le, input logic [XLEN-1:0] lv, input bit li);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        bus.in_valid   = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        lit_en  = le;
        lit_val = lv;
        lit_ill = li;
        while (!got) begin
            @(negedge clk);
            if (bus.in_ready && !reset) got = 1'b1;
            step();
            n++;
            if (!got && n > 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout at cycle %0d: got no in_ready, required accept within 200 cycles", cyc);
                got = 1'b1;
            end
        end
        bus.in_valid   = 1'b0;
        lit_en         = 1'b0;
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = 4'($urandom_range(0, 15));
    endtask

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return XLEN'($urandom_range(0, 15));
            3: return {1'b1, {(XLEN-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of run, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        rdy_mode = 0;
        lit_en = 1'b0;
        lit_val = '0;
        lit_ill = 1'b0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.SrcA = '0;
        bus.SrcB = '0;
        bus.ALUControl = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        issue(OP_ADD,  32'd7, 32'd5, 1, 32'd12, 0);
        issue(OP_SUB,  32'd5, 32'd5, 1, 32'd0, 0);
        issue(OP_SLT,  32'hFFFF_FFFF, 32'd1, 1, 32'd1, 0);
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0);
        issue(OP_SRA,  32'h8000_0000, 32'd4, 1, 32'hF800_0000, 0);
        issue(OP_ADD,  32'd1, 32'd2, 1, 32'd3, 0);
        issue(OP_ADD,  32'd10, 32'd20, 1, 32'd30, 0);
        issue(OP_ADD,  32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0);
        repeat (2) step();

        rdy_mode = 2;
        bus.out_ready = 1'b0;
        issue(OP_ADD, 32'd3, 32'd4, 1, 32'd7, 0);
        repeat (4) step();
        bus.out_ready = 1'b1;
        rdy_mode = 0;

        issue(OP_MUL,   32'h1_0000, 32'h1_0000, 1, 32'd0, !MD);
        issue(OP_MULHU, 32'h1_0000, 32'h1_0000, 1, MD ? 32'd1 : 32'd0, !MD);
        issue(OP_DIVU,  32'd100, 32'd7, 1, MD ? 32'd14 : 32'd0, !MD);
        issue(OP_REMU,  32'd100, 32'd7, 1, MD ? 32'd2 : 32'd0, !MD);
        issue(OP_DIVU,  32'd9, 32'd0, 1, MD ? 32'hFFFF_FFFF : 32'd0, !MD);
        issue(OP_REMU,  32'd9, 32'd0, 1, MD ? 32'd9 : 32'd0, !MD);
        issue(4'b1010,  32'd9, 32'd3, 1, 32'd0, 1);
        issue(4'b1011,  32'd1, 32'd1, 1, 32'd0, 1);
        repeat (XLEN + 4) step();

        issue(OP_DIVU, 32'd1000, 32'd7, 0, '0, 0);
        repeat (9) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        issue(OP_ADD, 32'd1, 32'd1, 1, 32'd2, 0);

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(), 0, '0, 0);
            repeat ($urandom_range(0, 2)) step();
        end

        rdy_mode = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
        end
        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
